tree_job_sequencer: RTL and testbench
=====================================

Name: tree_job_sequencer

Overview:
Sequences one evaluation tree (a root_* module with ST/RD/RES and five 16-bit operands) among NREQ independent requesters. Each requester submits a five-operand job. The sequencer arbitrates round-robin, drives the tree's operands and ST, waits for RD, and returns RES to the owner with a DONE pulse. A cycle timeout guards against a tree whose RD never rises. It sits between requester logic and the root_* instance, one sequencer per tree.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 256, max RUN cycles before a job is aborted with ERR; also bounds DRAIN
CW, 9, counter width; must satisfy 2^CW > TIMEOUT

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
REQ  in  NREQ  per-requester job request; level, held until ACK
REQ_OPS  in  NREQ*80  packed operands; requester i occupies bits [80i+79:80i], operand k at [80i+16k+15:80i+16k]
ACK  out  NREQ  one-cycle pulse: operands of requester i captured
DONE  out  NREQ  one-cycle pulse: job of requester i finished; RES/ERR valid
RES  out  16  result of the last finished job
ERR  out  1  last finished job timed out (RES=0)
BUSY  out  1  high whenever state != IDLE
TREE_ST  out  1  start level to tree
TREE_RD  in  1  tree ready
TREE_RES  in  16  tree result
TREE_IN0..TREE_IN4  out  16 each  tree operands

Behaviour:
- Clock is CLK. Reset is RST: asynchronous, active-low.
- While RST=0: state=IDLE, round-robin pointer=0, and all outputs are 0, including TREE_ST and TREE_IN*. TREE_ST drops immediately, even if reset asserts mid-job. The interrupted job gets no DONE.
- States: IDLE, RUN, DRAIN. All outputs are registered.
- IDLE:
  - If REQ is nonzero, grant the first set bit searching upward from the pointer, wrapping at NREQ.
  - On that edge: TREE_IN0..4 <= operands 0..4 of the winner; TREE_ST <= 1; ACK[winner] <= 1 for one cycle; owner <= winner; pointer <= (winner+1) mod NREQ; counter <= 0; go to RUN.
  - If REQ=0, stay in IDLE.
- RUN:
  - TREE_ST=1 and TREE_IN* are held stable. The counter increments each cycle.
  - If TREE_RD=1: RES <= TREE_RES; ERR <= 0; DONE[owner] <= 1 (one cycle); TREE_ST <= 0; counter <= 0; go to DRAIN.
  - Else, if counter = TIMEOUT-1: RES <= 0; ERR <= 1; DONE[owner] pulses; TREE_ST <= 0; go to DRAIN.
  - A TREE_RD sampled high on the RUN-entry edge does not exist; RD is sampled from the first RUN cycle onward.
- DRAIN:
  - TREE_ST=0; stay here at least one cycle.
  - Go to IDLE when TREE_RD=0, or when the counter reaches TIMEOUT-1 (ERR is not changed by a drain expiry).
  - No grants are issued in DRAIN.
- Latency:
  - REQ seen at edge k gives ACK and TREE_ST high in cycle k+1.
  - TREE_RD seen high at edge m gives DONE and RES in cycle m+1.
  - Minimum turnaround between grants is 3 cycles (RUN, DRAIN, IDLE).
- RES and ERR hold until the next DONE. DONE and ACK are never set for more than one requester at a time.
- REQ deasserted before ACK means no grant. REQ still high after ACK is treated as a new job, with its priority now lowest.
- Operand changes on REQ_OPS after ACK have no effect on the running job.

Test Plan:
- Single job, NREQ=4, tree model = sum of operands with 3-cycle RD latency. REQ=0001, ops 1,2,3,4,5 -> ACK[0] one cycle later; DONE[0] with RES=0x000F, ERR=0; BUSY back low after DRAIN.
- Round robin: REQ=1111 held continuously -> grant order 0,1,2,3,0; each DONE follows its ACK; no overlap of DONE bits.
- Timeout, TIMEOUT=16: tree RD stuck 0 -> DONE[owner] exactly 16 cycles after ACK, RES=0, ERR=1. The next job (RD working, ops all 0x0001) -> RES=0x0005, ERR=0.
- RD stuck 1 after a job: DRAIN exits after TIMEOUT cycles; the next grant proceeds normally.
- Async reset mid-RUN: RST=0 asserted between edges -> TREE_ST, BUSY, ACK, DONE and RES go 0 immediately. After release with REQ=0100 -> requester 2 is granted (pointer was reset to 0).
- Overflow wrap: ops 0xFFFF,1,0,0,0 with the sum model -> RES=0x0000, ERR=0 (width held to 16 bits, no flagging).

Source files
------------

// File: rtl/tree_job_sequencer.sv
// tree_job_sequencer: round-robin job sequencer in front of one evaluation tree.
// Requesters post five 16-bit operands; the winner's operands are launched
// into the tree with ST held high until RD. The result returns to the owner with
// a DONE pulse. A cycle counter aborts a run whose RD never rises and bounds the
// drain phase that waits for RD to fall.
module tree_job_sequencer #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CW      = 9
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*80-1:0]   REQ_OPS,
    output logic [NREQ-1:0]      ACK,
    output logic [NREQ-1:0]      DONE,
    output logic [15:0]          RES,
    output logic                 ERR,
    output logic                 BUSY,
    output logic                 TREE_ST,
    input  logic                 TREE_RD,
    input  logic [15:0]          TREE_RES,
    output logic [15:0]          TREE_IN0,
    output logic [15:0]          TREE_IN1,
    output logic [15:0]          TREE_IN2,
    output logic [15:0]          TREE_IN3,
    output logic [15:0]          TREE_IN4
);

    localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NOPS = 5;
    localparam int unsigned OPW  = 16;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Operand bus viewed as [requester][operand]; packed layout matches REQ_OPS.
    logic [NREQ-1:0][NOPS-1:0][OPW-1:0] req_ops;
    assign req_ops = REQ_OPS;

    state_t                   state_q, state_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [PW-1:0]            owner_q, owner_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [NOPS-1:0][OPW-1:0] tin_q, tin_d;
    logic [NREQ-1:0]          ack_d, done_d;
    logic [15:0]              res_d;
    logic                     err_d, busy_d, st_d;

    logic                     grant_vld;
    logic [PW-1:0]            grant_idx;
    logic [PW-1:0]            cand;

    assign TREE_IN0 = tin_q[0];
    assign TREE_IN1 = tin_q[1];
    assign TREE_IN2 = tin_q[2];
    assign TREE_IN3 = tin_q[3];
    assign TREE_IN4 = tin_q[4];

    // Round-robin search: first requesting index at or above the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = PW'((32'(ptr_q) + i) % NREQ);
            if (!grant_vld && REQ[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // State and output registers; reset clears everything, including the tree start.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            tin_q   <= '0;
            ACK     <= '0;
            DONE    <= '0;
            RES     <= '0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
            TREE_ST <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            tin_q   <= tin_d;
            ACK     <= ack_d;
            DONE    <= done_d;
            RES     <= res_d;
            ERR     <= err_d;
            BUSY    <= busy_d;
            TREE_ST <= st_d;
        end
    end

    // Next-state and next-output logic for IDLE -> RUN -> DRAIN -> IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        tin_d   = tin_q;
        ack_d   = '0;
        done_d  = '0;
        res_d   = RES;
        err_d   = ERR;
        st_d    = TREE_ST;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    tin_d   = req_ops[grant_idx];
                    st_d    = 1'b1;
                    ack_d   = NREQ'(1) << grant_idx;
                    owner_d = grant_idx;
                    ptr_d   = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (TREE_RD) begin
                    res_d   = TREE_RES;
                    err_d   = 1'b0;
                    done_d  = NREQ'(1) << owner_q;
                    st_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    // Tree never answered: abort with a zero result and flag it.
                    res_d   = '0;
                    err_d   = 1'b1;
                    done_d  = NREQ'(1) << owner_q;
                    st_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // Wait for RD to fall so the next job's RD is not a stale level.
                st_d  = 1'b0;
                cnt_d = cnt_q + CW'(1);
                if (!TREE_RD || (cnt_q == CNT_LAST)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                st_d    = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_tree_job_sequencer.sv
// Directed bench for tree_job_sequencer with a sum-of-operands tree model.
module tb_tree_job_sequencer;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CW      = 5;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic [NREQ-1:0]      REQ;
    logic [NREQ*80-1:0]   REQ_OPS;
    logic [NREQ-1:0]      ACK;
    logic [NREQ-1:0]      DONE;
    logic [15:0]          RES;
    logic                 ERR;
    logic                 BUSY;
    logic                 TREE_ST;
    logic                 TREE_RD;
    logic [15:0]          TREE_RES;
    logic [15:0]          TREE_IN0, TREE_IN1, TREE_IN2, TREE_IN3, TREE_IN4;

    int n_checks = 0;
    int n_errors = 0;
    int rd_mode  = 0;   // 0: RD three cycles after ST, 1: RD stuck low, 2: RD stuck high
    int lat      = 0;
    int n;
    int order [5] = '{0, 1, 2, 3, 0};

    tree_job_sequencer #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .REQ_OPS  (REQ_OPS),
        .ACK      (ACK),
        .DONE     (DONE),
        .RES      (RES),
        .ERR      (ERR),
        .BUSY     (BUSY),
        .TREE_ST  (TREE_ST),
        .TREE_RD  (TREE_RD),
        .TREE_RES (TREE_RES),
        .TREE_IN0 (TREE_IN0),
        .TREE_IN1 (TREE_IN1),
        .TREE_IN2 (TREE_IN2),
        .TREE_IN3 (TREE_IN3),
        .TREE_IN4 (TREE_IN4)
    );

    always #5 CLK = ~CLK;

    // Tree model: result is the 16-bit wrapping sum of its operands.
    assign TREE_RES = TREE_IN0 + TREE_IN1 + TREE_IN2 + TREE_IN3 + TREE_IN4;

    // Tree model: RD rises a fixed latency after ST and falls once ST drops.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            TREE_RD <= 1'b0;
            lat     <= 0;
        end else if (rd_mode == 1) begin
            TREE_RD <= 1'b0;
        end else if (rd_mode == 2) begin
            TREE_RD <= 1'b1;
        end else if (!TREE_ST) begin
            TREE_RD <= 1'b0;
            lat     <= 0;
        end else if (lat == 2) begin
            TREE_RD <= 1'b1;
        end else begin
            lat <= lat + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input int r, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d, input logic [15:0] e);
        REQ_OPS[r*80      +: 16] = a;
        REQ_OPS[r*80 + 16 +: 16] = b;
        REQ_OPS[r*80 + 32 +: 16] = c;
        REQ_OPS[r*80 + 48 +: 16] = d;
        REQ_OPS[r*80 + 64 +: 16] = e;
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (ACK == '0 && cyc < 40);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (DONE == '0 && cyc < 100);
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (BUSY && c < 100) begin
            @(negedge CLK);
            c++;
        end
        check(tag, 32'(BUSY), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        REQ     = '0;
        REQ_OPS = '0;
        RST     = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_ctl", 32'({ACK, DONE, ERR, BUSY, TREE_ST}), 32'd0);
        check("rst_res", 32'(RES), 32'd0);
        check("rst_in", 32'(TREE_IN0 | TREE_IN1 | TREE_IN2 | TREE_IN3 | TREE_IN4), 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Single job: ops 1..5 -> 0x000F
        set_ops(0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        REQ = 4'b0001;
        wait_ack(n);
        check("t1_ack", 32'(ACK), 32'h1);
        check("t1_ack_lat", 32'(n), 32'd1);
        check("t1_st", 32'(TREE_ST), 32'd1);
        check("t1_in", {TREE_IN0, TREE_IN4}, {16'd1, 16'd5});
        REQ = '0;
        @(negedge CLK);
        check("t1_ack_pulse", 32'(ACK), 32'd0);
        check("t1_busy", 32'(BUSY), 32'd1);
        wait_done(n);
        // RD visible 3 cycles after ST, DONE one cycle later; one cycle already consumed.
        check("t1_done_lat", 32'(n), 32'd3);
        check("t1_done", 32'(DONE), 32'h1);
        check("t1_res", 32'(RES), 32'h000F);
        check("t1_err", 32'(ERR), 32'd0);
        wait_idle("t1_idle");

        // Round robin with all requesters held
        do_reset();
        for (int i = 0; i < 4; i++)
            set_ops(i, 16'(i + 1), 16'(i + 1), 16'(i + 1), 16'(i + 1), 16'(i + 1));
        REQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_ack(n);
            check("rr_ack", 32'(ACK), 32'(1 << order[g]));
            if (g == 4) REQ = '0;
            wait_done(n);
            check("rr_done", 32'(DONE), 32'(1 << order[g]));
            check("rr_res", 32'(RES), 32'(5 * (order[g] + 1)));
        end
        wait_idle("rr_idle");

        // Timeout: RD stuck low
        rd_mode = 1;
        set_ops(1, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7);
        REQ = 4'b0010;
        wait_ack(n);
        check("to_ack", 32'(ACK), 32'h2);
        REQ = '0;
        wait_done(n);
        check("to_lat", 32'(n), 32'(TIMEOUT));
        check("to_done", 32'(DONE), 32'h2);
        check("to_res", 32'(RES), 32'd0);
        check("to_err", 32'(ERR), 32'd1);
        rd_mode = 0;
        wait_idle("to_idle");
        set_ops(2, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1);
        REQ = 4'b0100;
        wait_ack(n);
        check("to2_ack", 32'(ACK), 32'h4);
        REQ = '0;
        wait_done(n);
        check("to2_res", 32'(RES), 32'h0005);
        check("to2_err", 32'(ERR), 32'd0);
        wait_idle("to2_idle");

        // RD stuck high: drain bounded by the timeout
        rd_mode = 2;
        set_ops(3, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2);
        REQ = 4'b1000;
        wait_ack(n);
        check("st1_ack", 32'(ACK), 32'h8);
        REQ = '0;
        wait_done(n);
        check("st1_done_lat", 32'(n), 32'd1);
        check("st1_res", 32'(RES), 32'h000A);
        m = 0;
        while (BUSY && m < 100) begin
            @(negedge CLK);
            m++;
        end
        check("st1_drain_len", 32'(m), 32'(TIMEOUT));
        rd_mode = 0;
        set_ops(0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0);
        REQ = 4'b0001;
        wait_ack(n);
        check("st1_next_ack", 32'(ACK), 32'h1);
        REQ = '0;
        wait_done(n);
        check("st1_next_res", 32'(RES), 32'h0003);
        wait_idle("st1_idle");

        // Asynchronous reset in the middle of a run
        rd_mode = 1;
        set_ops(0, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9);
        REQ = 4'b0001;
        wait_ack(n);
        REQ = '0;
        repeat (3) @(negedge CLK);
        check("ar_pre_busy", 32'(BUSY), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check("ar_st", 32'(TREE_ST), 32'd0);
        check("ar_busy", 32'(BUSY), 32'd0);
        check("ar_ackdone", 32'({ACK, DONE}), 32'd0);
        check("ar_res", 32'(RES), 32'd0);
        check("ar_in", 32'(TREE_IN0), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        rd_mode = 0;
        set_ops(2, 16'h10, 16'h20, 16'h30, 16'h40, 16'h50);
        REQ = 4'b0101;
        wait_ack(n);
        check("ar_ptr_ack", 32'(ACK), 32'h1);
        REQ = 4'b0100;
        wait_done(n);
        check("ar_job0_done", 32'(DONE), 32'h1);
        check("ar_job0_res", 32'(RES), 32'h002D);
        wait_ack(n);
        check("ar_req2_ack", 32'(ACK), 32'h4);
        REQ = '0;
        wait_done(n);
        check("ar_req2_res", 32'(RES), 32'h00F0);
        wait_idle("ar_idle");

        // 16-bit wrap of the result; late operand change must not leak in
        set_ops(1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
        REQ = 4'b0010;
        wait_ack(n);
        check("ov_ack", 32'(ACK), 32'h2);
        REQ = '0;
        set_ops(1, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5);
        @(negedge CLK);
        check("ov_hold", 32'(TREE_IN0), 32'h0000FFFF);
        wait_done(n);
        check("ov_done", 32'(DONE), 32'h2);
        check("ov_res", 32'(RES), 32'h0000);
        check("ov_err", 32'(ERR), 32'd0);
        wait_idle("ov_idle");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
